cp_wb_wr_arb: RTL and testbench

RF write-port arbiter and write-back register for the CP core. It replaces the single-source write-back stage and shares the one RF write port between two sources: the in-order EX pipeline, which always wins, and a long-latency return channel, which carries load or multi-cycle unit results and is buffered in a small pending FIFO. A starvation guard can request a one-slot pipeline stall so that buffered returns drain.

---
 rtl/cp_wb_wr_arb.sv | 156 +++++++++++++++
 tb/tb_cp_wb_wr_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cp_wb_wr_arb.sv
// RF write-port arbiter: the EX pipeline always wins, long-latency returns wait in a pending FIFO.
// Starvation guard (stall request) is built only when CP_WB_ARB_STARVE_GUARD_EN is defined.
`ifndef DEF_CP_RF_INDEX_WIDTH
`define DEF_CP_RF_INDEX_WIDTH 5
`endif
`ifndef DEF_CP_DATA_WIDTH
`define DEF_CP_DATA_WIDTH 32
`endif

module cp_wb_wr_arb #(
  parameter int unsigned PEND_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iEX_WB_Write_RF_Enable,
  input  logic [`DEF_CP_RF_INDEX_WIDTH-1:0] iEX_WB_Write_RF_Address,
  input  logic [`DEF_CP_DATA_WIDTH-1:0]     iEX_WB_Write_RF_Data,
  input  logic                              iRT_Valid,
  input  logic [`DEF_CP_RF_INDEX_WIDTH-1:0] iRT_Address,
  input  logic [`DEF_CP_DATA_WIDTH-1:0]     iRT_Data,
  output logic                              oRT_Ready,
  output logic                              oWB_RF_Writeback_Enable,
  output logic [`DEF_CP_RF_INDEX_WIDTH-1:0] oWB_RF_Write_Addr,
  output logic [`DEF_CP_DATA_WIDTH-1:0]     oWB_RF_Write_Data,
  output logic                              oWB_Stall_Req,
  output logic [$clog2(PEND_DEPTH):0]       oPend_Count
);
  localparam int unsigned PTR_W = $clog2(PEND_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(PEND_DEPTH);

  if (PEND_DEPTH < 2 || PEND_DEPTH > 8 || (PEND_DEPTH & (PEND_DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_cfg_check
    $error("cp_wb_wr_arb: unsupported PEND_DEPTH or STARVE_LIMIT");
  end

  logic [`DEF_CP_RF_INDEX_WIDTH-1:0] r_addr [PEND_DEPTH];
  logic [`DEF_CP_DATA_WIDTH-1:0]     r_data [PEND_DEPTH];
  logic [PEND_DEPTH-1:0]             r_vld;
  logic [PTR_W-1:0]                  r_head;
  logic [PTR_W-1:0]                  r_tail;
  logic [PTR_W:0]                    r_count;

  logic w_nonempty;
  logic w_push;
  logic w_pop;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign oRT_Ready   = !iReset && (r_count != FULL_CNT);
  assign w_nonempty  = (r_count != '0);
  assign w_push      = iRT_Valid && oRT_Ready;
  assign w_pop       = !iEX_WB_Write_RF_Enable && w_nonempty;
  assign oPend_Count = r_count;

  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_addr[r_tail] <= iRT_Address;
      r_data[r_tail] <= iRT_Data;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_head                  <= '0;
      r_tail                  <= '0;
      r_count                 <= '0;
      r_vld                   <= '0;
      oWB_RF_Writeback_Enable <= 1'b0;
      oWB_RF_Write_Addr       <= '0;
      oWB_RF_Write_Data       <= '0;
    end else begin
      if (iEX_WB_Write_RF_Enable) begin
        oWB_RF_Writeback_Enable <= 1'b1;
        oWB_RF_Write_Addr       <= iEX_WB_Write_RF_Address;
        oWB_RF_Write_Data       <= iEX_WB_Write_RF_Data;
        // Older pending returns to the same register must not overwrite this write.
        for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
          if (r_addr[PTR_W'(i)] == iEX_WB_Write_RF_Address) r_vld[PTR_W'(i)] <= 1'b0;
        end
      end else if (w_pop) begin
        oWB_RF_Writeback_Enable <= r_vld[r_head];
        oWB_RF_Write_Addr       <= r_addr[r_head];
        oWB_RF_Write_Data       <= r_data[r_head];
        r_head                  <= r_head + 1'b1;
      end else begin
        oWB_RF_Writeback_Enable <= 1'b0;
      end

      // A push lands after the kill loop, so a same-cycle younger return stays valid.
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef CP_WB_ARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_FORCE} guard_state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  guard_state_t r_state;
  logic [7:0]   r_starve_cnt;
  logic         r_stall;
  logic         w_starved;

  assign w_starved     = iEX_WB_Write_RF_Enable && w_nonempty;
  assign oWB_Stall_Req = r_stall;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_stall <= (r_state == ST_FORCE);
      unique case (r_state)
        ST_IDLE: begin
          if (w_starved) begin
            r_state      <= ST_COUNT;
            r_starve_cnt <= 8'd1;
          end
        end
        ST_COUNT: begin
          if (w_pop || !w_nonempty) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
          end else if (r_starve_cnt == LIMIT) begin
            r_state <= ST_FORCE;
          end else if (w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        ST_FORCE: begin
          if (w_pop) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end
`else
  assign oWB_Stall_Req = 1'b0;
`endif

endmodule

// File: tb/tb_cp_wb_wr_arb.sv
// Directed bench for cp_wb_wr_arb (PEND_DEPTH=4, STARVE_LIMIT=8, 5-bit index, 32-bit data).
module tb_cp_wb_wr_arb;
  localparam int unsigned IW = 5;
  localparam int unsigned DW = 32;
`ifdef CP_WB_ARB_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic          iClk;
  logic          iReset;
  logic          ex_en;
  logic [IW-1:0] ex_addr;
  logic [DW-1:0] ex_data;
  logic          rt_valid;
  logic [IW-1:0] rt_addr;
  logic [DW-1:0] rt_data;
  logic          rt_ready;
  logic          wb_en;
  logic [IW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          stall;
  logic [2:0]    pend;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  cp_wb_wr_arb #(.PEND_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .iClk                    (iClk),
    .iReset                  (iReset),
    .iEX_WB_Write_RF_Enable  (ex_en),
    .iEX_WB_Write_RF_Address (ex_addr),
    .iEX_WB_Write_RF_Data    (ex_data),
    .iRT_Valid               (rt_valid),
    .iRT_Address             (rt_addr),
    .iRT_Data                (rt_data),
    .oRT_Ready               (rt_ready),
    .oWB_RF_Writeback_Enable (wb_en),
    .oWB_RF_Write_Addr       (wb_addr),
    .oWB_RF_Write_Data       (wb_data),
    .oWB_Stall_Req           (stall),
    .oPend_Count             (pend)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [IW-1:0] a,
                        input logic [DW-1:0] d, input logic [2:0] cnt);
    chk({tag, ".en"}, 32'(wb_en), 32'(en));
    chk({tag, ".addr"}, 32'(wb_addr), 32'(a));
    chk({tag, ".data"}, wb_data, d);
    chk({tag, ".pend"}, 32'(pend), 32'(cnt));
  endtask

  task automatic drive_ex(input logic en, input logic [IW-1:0] a, input logic [DW-1:0] d);
    ex_en = en; ex_addr = a; ex_data = d;
  endtask

  task automatic drive_rt(input logic v, input logic [IW-1:0] a, input logic [DW-1:0] d);
    rt_valid = v; rt_addr = a; rt_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1;
    drive_ex(1'b0, '0, '0);
    drive_rt(1'b0, '0, '0);

    // Reset state
    tick(); tick();
    chk_wb("reset", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("reset.ready", 32'(rt_ready), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    iReset = 1'b0;
    tick();
    chk("post_reset.ready", 32'(rt_ready), 32'd1);
    chk("post_reset.en", 32'(wb_en), 32'd0);

    // Pipeline only: 1-cycle latency, address/data hold when idle
    drive_ex(1'b1, 5'd3, 32'h1234);
    tick();
    chk_wb("pipe", 1'b1, 5'd3, 32'h1234, 3'd0);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("pipe_idle", 1'b0, 5'd3, 32'h1234, 3'd0);

    // Return only: accepted at edge N, written after edge N+1 of the pop
    drive_rt(1'b1, 5'd7, 32'hABCD);
    tick();
    drive_rt(1'b0, 5'd0, 32'h0);
    chk("ret.pend1", 32'(pend), 32'd1);
    chk("ret.en_wait", 32'(wb_en), 32'd0);
    tick();
    chk_wb("ret", 1'b1, 5'd7, 32'hABCD, 3'd0);
    tick();
    chk("ret_idle.en", 32'(wb_en), 32'd0);

    // Full: four pushes with the pipeline busy, a fifth held back
    drive_ex(1'b1, 5'd1, 32'h100);
    for (int unsigned k = 0; k < 4; k++) begin
      drive_rt(1'b1, 5'(10 + k), 32'hA0 + k);
      tick();
      chk("full.pend", 32'(pend), k + 1);
    end
    chk("full.ready", 32'(rt_ready), 32'd0);
    chk_wb("full.pipe", 1'b1, 5'd1, 32'h100, 3'd4);
    drive_rt(1'b1, 5'd14, 32'hA4);
    tick();
    chk("held.pend", 32'(pend), 32'd4);
    chk("held.ready", 32'(rt_ready), 32'd0);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("drain0", 1'b1, 5'd10, 32'hA0, 3'd3);
    chk("drain0.ready", 32'(rt_ready), 32'd1);
    tick();
    drive_rt(1'b0, 5'd0, 32'h0);
    chk_wb("drain1", 1'b1, 5'd11, 32'hA1, 3'd3);
    tick();
    chk_wb("drain2", 1'b1, 5'd12, 32'hA2, 3'd2);
    tick();
    chk_wb("drain3", 1'b1, 5'd13, 32'hA3, 3'd1);
    tick();
    chk_wb("drain4", 1'b1, 5'd14, 32'hA4, 3'd0);
    tick();
    chk("drain_idle.en", 32'(wb_en), 32'd0);

    // Ordering kill: younger pipeline write to r5 invalidates the pending return
    drive_ex(1'b1, 5'd9, 32'h99);
    drive_rt(1'b1, 5'd5, 32'h1);
    tick();
    chk_wb("kill.push", 1'b1, 5'd9, 32'h99, 3'd1);
    drive_rt(1'b0, 5'd0, 32'h0);
    drive_ex(1'b1, 5'd5, 32'h2);
    tick();
    chk_wb("kill.pipe", 1'b1, 5'd5, 32'h2, 3'd1);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("kill.pop", 1'b0, 5'd5, 32'h1, 3'd0);

    // Same-cycle push and matching pipeline write: the return is younger and survives
    drive_ex(1'b1, 5'd6, 32'h7);
    drive_rt(1'b1, 5'd6, 32'h6);
    tick();
    chk_wb("nokill.pipe", 1'b1, 5'd6, 32'h7, 3'd1);
    drive_ex(1'b0, 5'd0, 32'h0);
    drive_rt(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("nokill.pop", 1'b1, 5'd6, 32'h6, 3'd0);

    // Starvation: one pending entry, continuous pipeline writes
    drive_ex(1'b1, 5'd2, 32'h200);
    drive_rt(1'b1, 5'd20, 32'h55);
    tick();
    drive_rt(1'b0, 5'd0, 32'h0);
    for (int unsigned k = 1; k <= 9; k++) begin
      drive_ex(1'b1, 5'd2, 32'h200 + k);
      tick();
      chk("starve.stall_low", 32'(stall), 32'd0);
    end
    tick();
    chk("starve.stall_rise", 32'(stall), 32'(GUARD));
    chk_wb("starve.pipe_wins", 1'b1, 5'd2, 32'h209, 3'd1);
    tick();
    chk("starve.stall_hold", 32'(stall), 32'(GUARD));
    chk("starve.pend", 32'(pend), 32'd1);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("starve.pop", 1'b1, 5'd20, 32'h55, 3'd0);
    chk("starve.stall_pop", 32'(stall), 32'(GUARD));
    tick();
    chk("starve.stall_clear", 32'(stall), 32'd0);

    // Reset mid-drain: three pending entries are flushed and never written
    drive_ex(1'b1, 5'd2, 32'h300);
    for (int unsigned k = 0; k < 3; k++) begin
      drive_rt(1'b1, 5'(21 + k), 32'hB1 + k);
      tick();
    end
    chk("rst.pend3", 32'(pend), 32'd3);
    drive_rt(1'b0, 5'd0, 32'h0);
    drive_ex(1'b0, 5'd0, 32'h0);
    iReset = 1'b1;
    tick();
    chk_wb("rst.flush", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("rst.ready", 32'(rt_ready), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    iReset = 1'b0;
    tick();
    chk_wb("rst.after1", 1'b0, 5'd0, 32'h0, 3'd0);
    tick();
    chk_wb("rst.after2", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("rst.ready_back", 32'(rt_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
